multi_led_controller: RTL

Parametrised multi-channel successor to the single-LED button controller. It drives NUM_CH independent PWM LED channels from four active-low push buttons: mode, up, down and channel-select. Each channel has its own mode (manual, breathing, blink) and its own stored duty level. It sits between the board's raw button pins and the LED pins and shares one debouncer set, one PWM timebase and one breathing/blink generator across all channels.

---
 rtl/multi_led_controller.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_led_controller.sv
// Multi-channel PWM LED controller driven by four active-low push buttons.
// One debouncer set, one PWM timebase and one breath/blink generator are shared by all
// channels. Each channel has its own mode and its own stored duty level.
module multi_led_controller #(
    parameter int unsigned CLK_FREQ_HZ      = 100_000,
    parameter int unsigned DEBOUNCE_TIME_MS = 10,
    parameter int unsigned PWM_FREQ         = 1_000,
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned DUTY_STEPS       = 10,
    parameter int unsigned BREATH_PERIOD_MS = 20,
    parameter int unsigned BLINK_HALF_MS    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_mode_in,
    input  logic                      btn_up_in,
    input  logic                      btn_down_in,
    input  logic                      btn_sel_in,
    output logic [NUM_CH-1:0]         led_out,
    output logic [1:0]                mode_led_out,
    output logic [$clog2(NUM_CH)-1:0] sel_ch_out
);

    localparam int unsigned PwmPeriod  = CLK_FREQ_HZ / PWM_FREQ;
    localparam int unsigned DutyCyc    = PwmPeriod / DUTY_STEPS;
    localparam int unsigned DbCycles   = CLK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;
    localparam int unsigned BreathStep = CLK_FREQ_HZ / 1000 * BREATH_PERIOD_MS / (2 * DUTY_STEPS);
    localparam int unsigned BlinkHalf  = CLK_FREQ_HZ / 1000 * BLINK_HALF_MS;

    localparam int unsigned PwmW    = $clog2(PwmPeriod + 1);
    localparam int unsigned DbW     = $clog2(DbCycles + 1);
    localparam int unsigned BreathW = $clog2(BreathStep + 1);
    localparam int unsigned BlinkW  = $clog2(BlinkHalf + 1);
    localparam int unsigned LvlW    = $clog2(DUTY_STEPS + 1);
    localparam int unsigned SelW    = $clog2(NUM_CH);

    // Button bit positions within the shared debouncer vectors
    localparam int unsigned BtnMode = 0;
    localparam int unsigned BtnUp   = 1;
    localparam int unsigned BtnDown = 2;
    localparam int unsigned BtnSel  = 3;

    typedef enum logic [1:0] {
        ModeManual = 2'b00,
        ModeBreath = 2'b01,
        ModeBlink  = 2'b10
    } mode_e;

    // ---------------- Debounce ----------------
    logic [3:0]     btn_raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     stable_q, stable_d;
    logic [3:0]     press_q, press_d;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];

    assign btn_raw = {btn_sel_in, btn_down_in, btn_up_in, btn_mode_in};

    // Debounce next state: accept a change only after it held for DbCycles cycles
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int b = 0; b < 4; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DbW'(DbCycles - 1)) begin
                    stable_d[b] = sync2_q[b];
                    press_d[b]  = ~sync2_q[b];  // only the 1->0 edge is a press
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Synchroniser, stable level, debounce counters and press pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            press_q  <= '0;
            for (int b = 0; b < 4; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int b = 0; b < 4; b++) db_cnt_q[b] <= db_cnt_d[b];
        end
    end

    // ---------------- Channel state ----------------
    logic [SelW-1:0] sel_q, sel_d;
    logic [LvlW-1:0] level_q [NUM_CH];
    logic [LvlW-1:0] level_d [NUM_CH];
    mode_e           mode_q  [NUM_CH];
    mode_e           mode_d  [NUM_CH];

    // Button actions; mode/up/down act on the selection before any sel update
    always_comb begin
        sel_d   = sel_q;
        level_d = level_q;
        mode_d  = mode_q;
        if (press_q[BtnSel]) begin
            sel_d = (sel_q == SelW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
        end
        if (press_q[BtnMode]) begin
            unique case (mode_q[sel_q])
                ModeManual: mode_d[sel_q] = ModeBreath;
                ModeBreath: mode_d[sel_q] = ModeBlink;
                default:    mode_d[sel_q] = ModeManual;
            endcase
        end
        if (press_q[BtnUp] && !press_q[BtnDown] && level_q[sel_q] != LvlW'(DUTY_STEPS)) begin
            level_d[sel_q] = level_q[sel_q] + 1'b1;
        end
        if (press_q[BtnDown] && !press_q[BtnUp] && level_q[sel_q] != '0) begin
            level_d[sel_q] = level_q[sel_q] - 1'b1;
        end
    end

    // Selection, per-channel levels and modes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                level_q[i] <= '0;
                mode_q[i]  <= ModeManual;
            end
        end else begin
            sel_q   <= sel_d;
            level_q <= level_d;
            mode_q  <= mode_d;
        end
    end

    // ---------------- Shared timebases ----------------
    logic [PwmW-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [BreathW-1:0] br_cnt_q, br_cnt_d;
    logic [LvlW-1:0]    br_lvl_q, br_lvl_d;
    logic               br_up_q, br_up_d;
    logic [BlinkW-1:0]  bl_cnt_q, bl_cnt_d;
    logic               bl_on_q, bl_on_d;

    // PWM counter, breath triangle and blink phase
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PwmW'(PwmPeriod - 1)) ? '0 : pwm_cnt_q + 1'b1;

        br_cnt_d = br_cnt_q + 1'b1;
        br_lvl_d = br_lvl_q;
        br_up_d  = br_up_q;
        if (br_cnt_q == BreathW'(BreathStep - 1)) begin
            br_cnt_d = '0;
            // Reverse on arriving at an endpoint so each endpoint lasts exactly one step
            if (br_up_q) begin
                br_lvl_d = br_lvl_q + 1'b1;
                if (br_lvl_q == LvlW'(DUTY_STEPS - 1)) br_up_d = 1'b0;
            end else begin
                br_lvl_d = br_lvl_q - 1'b1;
                if (br_lvl_q == LvlW'(1)) br_up_d = 1'b1;
            end
        end

        bl_cnt_d = bl_cnt_q + 1'b1;
        bl_on_d  = bl_on_q;
        if (bl_cnt_q == BlinkW'(BlinkHalf - 1)) begin
            bl_cnt_d = '0;
            bl_on_d  = ~bl_on_q;
        end
    end

    // Timebase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            br_cnt_q  <= '0;
            br_lvl_q  <= '0;
            br_up_q   <= 1'b1;
            bl_cnt_q  <= '0;
            bl_on_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            br_cnt_q  <= br_cnt_d;
            br_lvl_q  <= br_lvl_d;
            br_up_q   <= br_up_d;
            bl_cnt_q  <= bl_cnt_d;
            bl_on_q   <= bl_on_d;
        end
    end

    // ---------------- PWM compare and outputs ----------------
    logic [LvlW-1:0]   eff   [NUM_CH];
    logic [PwmW-1:0]   cmp_q [NUM_CH];
    logic [PwmW-1:0]   cmp_d [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic [1:0]        mode_out_q;
    logic [SelW-1:0]   sel_out_q;

    // Effective level per channel; compare value reloads only at the period boundary
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            unique case (mode_q[i])
                ModeBreath: eff[i] = br_lvl_q;
                ModeBlink:  eff[i] = bl_on_q ? level_q[i] : '0;
                default:    eff[i] = level_q[i];
            endcase
            cmp_d[i] = (pwm_cnt_d == '0) ? PwmW'(eff[i] * DutyCyc) : cmp_q[i];
            led_d[i] = pwm_cnt_q < cmp_q[i];
        end
    end

    // Compare registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) cmp_q[i] <= '0;
            led_q      <= '0;
            mode_out_q <= 2'b00;
            sel_out_q  <= '0;
        end else begin
            cmp_q      <= cmp_d;
            led_q      <= led_d;
            mode_out_q <= mode_q[sel_q];
            sel_out_q  <= sel_q;
        end
    end

    assign led_out      = led_q;
    assign mode_led_out = mode_out_q;
    assign sel_ch_out   = sel_out_q;

endmodule
